suma_serial: RTL
================

SUMA_SERIAL -- requirements
Module: suma_serial

Interface
REQ-001 SHALL have parameter: N, default 4, operand/result width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 SHALL have port: A_num  input  N  first operand; sampled only when start is accepted.
REQ-006 SHALL have port: B_num  input  N  second operand; sampled only when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while the adder is in state RUN.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when a new result is valid.
REQ-009 SHALL have port: result  output  N  A_num + B_num, modulo 2^N.
REQ-010 SHALL have port: carry  output  1  unsigned carry out of bit N-1.
REQ-011 SHALL have port: overflow  output  1  two's-complement overflow, equal to carry into bit N-1 XOR carry out of bit N-1.

Function
REQ-012 SHALL implement a bit-serial adder: one full-adder cell, one bit per clock, LSB first.
REQ-013 SHALL implement the full-adder cell as sum = a^b^c and cout = ab|ac|bc.
REQ-014 SHALL implement the FSM with states IDLE, RUN and DONE, and SHALL encode state in registers only.
REQ-015 SHALL, in IDLE with start=1 at an edge, load A_num/B_num into internal shift registers, clear the carry flip-flop and bit counter, and go to RUN.
REQ-016 SHALL, in IDLE with start=0, remain in IDLE.
REQ-017 SHALL, in RUN, compute the bit at index counter on each edge, shift the sum bit into the internal sum register at the MSB end, update the carry flip-flop, and increment the counter.
REQ-018 SHALL keep the previous carry flip-flop value as the carry into bit N-1 when processing bit N-1, for overflow.
REQ-019 SHALL, on the edge that processes bit N-1, go to DONE and copy the completed sum, carry and overflow into the result, carry and overflow output registers in the same edge.
REQ-020 SHALL ignore start while in RUN; the operation in progress continues unchanged.
REQ-021 SHALL, in DONE, hold done=1 for exactly one cycle; the next edge goes to RUN if start=1 (back-to-back, new operands loaded) and to IDLE otherwise.
REQ-022 SHALL give a latency such that start accepted at edge t0 yields done high in the cycle following edge t0+N, so consecutive operations complete every N+1 cycles.
REQ-023 SHALL drive busy combinationally from state==RUN and done from state==DONE.
REQ-024 SHALL keep result/carry/overflow stable from one completion until the next completion, and SHALL NOT let them change during RUN.
REQ-025 SHALL size the counter at ceil(log2 N) bits; it SHALL NOT wrap before reaching N-1.
REQ-026 SHALL accept operand changes on A_num/B_num outside the accepting edge without any effect.

Reset
REQ-027 SHALL, on rst_n=0, immediately (asynchronously) set state=IDLE and busy=0, done=0, result=0, carry=0, overflow=0, and clear the counter, carry flip-flop and shift registers.
REQ-028 SHALL, on reset asserted during RUN, abort the operation, produce no done pulse, and leave outputs at reset values.
REQ-029 SHALL, after rst_n deasserts, accept start at the first rising edge with rst_n=1.

Verification
REQ-030 SHALL verify, with N=4: A=3, B=5, start one cycle -> busy for 4 cycles, done pulse, result=4'b1000, carry=0, overflow=1.
REQ-031 SHALL verify, with N=4: A=15, B=1 -> result=0, carry=1, overflow=0; A=8, B=8 -> result=0, carry=1, overflow=1.
REQ-032 SHALL verify, with N=4: A=2, B=3 started, then start held high with A=9, B=9 during RUN -> result=5, carry=0, overflow=0; the second start is accepted only in DONE, and its result 4'b0010, carry=1, overflow=1 appears 5 cycles later.
REQ-033 SHALL verify that result keeps its prior value during RUN: result=8 from REQ-030, then a new 1+1 operation -> result stays 8 until the done pulse, then becomes 2.
REQ-034 SHALL verify reset asserted mid-RUN (after 2 bits) -> immediate busy=0, outputs 0, no done pulse; a fresh 6+7 afterwards -> result=13, carry=0, overflow=1.
REQ-035 SHALL verify with N=8 and a random sweep of 1000 operand pairs that result, carry and overflow match the reference A+B model.

Source files
------------

// File: rtl/suma_serial.sv
// suma_serial: bit-serial two-operand adder built around a single full-adder cell.
// Operands are shifted out LSB first, one bit per clock, and the sum is
// assembled from the MSB end. A three-state FSM (IDLE/RUN/DONE) sequences
// each addition. The result, carry and overflow registers only change on the
// edge that completes an addition.
module suma_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  sum_sh;
  logic [CW-1:0] cnt;
  logic          c_ff;

  logic          fa_a;
  logic          fa_b;
  logic          fa_s;
  logic          fa_co;
  logic [N-1:0]  sum_next;

  // The full-adder cell works on the current LSB of each operand shift
  // register, which is the operand bit at index cnt.
  assign fa_a     = a_sh[0];
  assign fa_b     = b_sh[0];
  assign fa_s     = fa_a ^ fa_b ^ c_ff;
  assign fa_co    = (fa_a & fa_b) | (fa_a & c_ff) | (fa_b & c_ff);
  // The sum register after this bit is shifted in; on the last bit this is
  // the completed sum, so it can be copied to result in the same edge.
  assign sum_next = {fa_s, sum_sh[N-1:1]};

  // Status flags are pure decodes of the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Sequencer, datapath shift registers and output registers.
  // NOTE: every register here, including the output registers, is cleared by
  // the asynchronous reset so an aborted addition leaves no partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      c_ff     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= A_num;
            b_sh   <= B_num;
            sum_sh <= '0;
            cnt    <= '0;
            c_ff   <= 1'b0;
            state  <= RUN;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          c_ff   <= fa_co;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // c_ff still holds the carry into bit N-1 on this edge.
            result   <= sum_next;
            carry    <= fa_co;
            overflow <= c_ff ^ fa_co;
            state    <= DONE;
          end
        end

        DONE: begin
          if (start) begin
            a_sh   <= A_num;
            b_sh   <= B_num;
            sum_sh <= '0;
            cnt    <= '0;
            c_ff   <= 1'b0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
